// File: rtl/crossbar_alloc.sv
// Wormhole switch allocator. Each output port has its own round-robin arbiter.
// An output stays locked to its winning input from the head flit through the
// tail flit. The allocator drives crossbar select lines and per-input grants.
module crossbar_alloc #(
  parameter  int PORTS = 4,
  localparam int DW    = $clog2(PORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORTS-1:0]          req_i,
  input  logic [PORTS-1:0][DW-1:0]  dest_i,
  input  logic [PORTS-1:0]          tail_i,
  input  logic [PORTS-1:0]          ready_i,
  output logic [PORTS-1:0][DW-1:0]  sel_o,
  output logic [PORTS-1:0]          sel_valid_o,
  output logic [PORTS-1:0]          gnt_o,
  output logic [PORTS-1:0]          lock_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Successor modulo PORTS. This is written explicitly so that a
  // non-power-of-2 port count never produces an out-of-range pointer.
  function automatic logic [DW-1:0] next_idx(input logic [DW-1:0] x);
    return (x == DW'(PORTS - 1)) ? '0 : x + DW'(1);
  endfunction

  logic [PORTS-1:0] w_xfer;

  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_out
      state_t           r_st, w_st_next;
      logic [DW-1:0]    r_owner, w_owner_next;
      logic [DW-1:0]    r_ptr, w_ptr_next;
      logic [PORTS-1:0] w_cand;
      logic             w_found;
      logic [DW-1:0]    w_winner;
      logic [DW-1:0]    w_sel;
      logic             w_sel_valid;

      // Build the set of inputs whose current flit targets this output.
      always_comb begin
        for (int i = 0; i < PORTS; i++) begin
          w_cand[i] = req_i[i] && (dest_i[i] == DW'(gi));
        end
      end

      // Scan the candidates in rotating order, starting at the priority pointer.
      always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < PORTS; k++) begin
          idx = int'(r_ptr) + k;
          if (idx >= PORTS) idx = idx - PORTS;
          if (!w_found && w_cand[idx]) begin
            w_found  = 1'b1;
            w_winner = DW'(idx);
          end
        end
      end

      // Compute the crossbar select for this output and the next lock/owner/pointer.
      always_comb begin
        w_st_next    = r_st;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_sel        = '0;
        w_sel_valid  = 1'b0;
        case (r_st)
          ST_IDLE: begin
            if (w_found) begin
              w_sel       = w_winner;
              w_sel_valid = 1'b1;
              if (ready_i[gi] && tail_i[w_winner]) begin
                w_ptr_next = next_idx(w_winner);
              end else begin
                // Once chosen, the winner keeps the output even if it stalls on its head flit.
                w_st_next    = ST_LOCKED;
                w_owner_next = w_winner;
              end
            end
          end
          ST_LOCKED: begin
            // The output is valid only while the owner still presents a flit for this output.
            w_sel       = r_owner;
            w_sel_valid = w_cand[r_owner];
            if (w_sel_valid && ready_i[gi] && tail_i[r_owner]) begin
              w_st_next  = ST_IDLE;
              w_ptr_next = next_idx(r_owner);
            end
          end
          default: w_st_next = ST_IDLE;
        endcase
      end

      // Hold the per-output lock state, owner and priority pointer.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_st    <= ST_IDLE;
          r_owner <= '0;
          r_ptr   <= '0;
        end else begin
          r_st    <= w_st_next;
          r_owner <= w_owner_next;
          r_ptr   <= w_ptr_next;
        end
      end

      assign sel_o[gi]       = w_sel;
      assign sel_valid_o[gi] = w_sel_valid;
      assign lock_o[gi]      = (r_st == ST_LOCKED);
      assign w_xfer[gi]      = w_sel_valid && ready_i[gi];
    end
  endgenerate

  // Return a grant to each input whose flit crosses the crossbar this cycle.
  always_comb begin
    gnt_o = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (w_xfer[o] && (sel_o[o] == DW'(i))) gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_alloc.sv
// Testbench for crossbar_alloc with PORTS=4. It runs directed scenarios and then
// a random run. A packet-level reference model supplies the expected outputs.
module tb_crossbar_alloc;

  localparam int P = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [3:0][1:0] dest = '0;
  logic [3:0]      tail = '0;
  logic [3:0]      ready = '0;
  logic [3:0][1:0] sel;
  logic [3:0]      sel_valid;
  logic [3:0]      gnt;
  logic [3:0]      lock;

  int checks = 0;
  int errors = 0;

  // Reference model state for each output: whether it is locked, who owns it,
  // and which input has priority next.
  bit m_locked[P];
  int m_owner[P];
  int m_ptr[P];

  // Outputs seen in the most recent cycle, used by the directed step checks.
  logic [3:0][1:0] l_sel;
  logic [3:0]      l_sv, l_gnt, l_lock;

  crossbar_alloc #(.PORTS(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .dest_i     (dest),
    .tail_i     (tail),
    .ready_i    (ready),
    .sel_o      (sel),
    .sel_valid_o(sel_valid),
    .gnt_o      (gnt),
    .lock_o     (lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < P; o++) begin
      m_locked[o] = 1'b0;
      m_owner[o]  = 0;
      m_ptr[o]    = 0;
    end
  endtask

  function automatic bit wants(int i, int o);
    return req[i] && (int'(dest[i]) == o);
  endfunction

  // Run one clock cycle. At the falling edge, compare the outputs with the
  // model. At the rising edge, advance the model.
  task automatic cycle(input string tag);
    logic [3:0][1:0] e_sel;
    logic [3:0]      e_sv, e_gnt, e_lock;
    bit              n_locked[P];
    int              n_owner[P], n_ptr[P];
    int              win;
    @(negedge clk);
    e_sel = '0; e_sv = '0; e_gnt = '0; e_lock = '0;
    for (int o = 0; o < P; o++) begin
      n_locked[o] = m_locked[o];
      n_owner[o]  = m_owner[o];
      n_ptr[o]    = m_ptr[o];
      e_lock[o]   = m_locked[o];
      if (!m_locked[o]) begin
        win = -1;
        for (int k = 0; k < P; k++) begin
          if (win < 0 && wants((m_ptr[o] + k) % P, o)) win = (m_ptr[o] + k) % P;
        end
        if (win >= 0) begin
          e_sel[o] = 2'(win);
          e_sv[o]  = 1'b1;
          if (ready[o]) e_gnt[win] = 1'b1;
          if (ready[o] && tail[win]) begin
            n_ptr[o] = (win + 1) % P;
          end else begin
            n_locked[o] = 1'b1;
            n_owner[o]  = win;
          end
        end
      end else begin
        e_sel[o] = 2'(m_owner[o]);
        e_sv[o]  = wants(m_owner[o], o);
        if (e_sv[o] && ready[o]) begin
          e_gnt[m_owner[o]] = 1'b1;
          if (tail[m_owner[o]]) begin
            n_locked[o] = 1'b0;
            n_ptr[o]    = (m_owner[o] + 1) % P;
          end
        end
      end
    end
    l_sel = sel; l_sv = sel_valid; l_gnt = gnt; l_lock = lock;
    chk({tag, "_sel"},       32'(sel),       32'(e_sel));
    chk({tag, "_sel_valid"}, 32'(sel_valid), 32'(e_sv));
    chk({tag, "_gnt"},       32'(gnt),       32'(e_gnt));
    chk({tag, "_lock"},      32'(lock),      32'(e_lock));
    @(posedge clk);
    for (int o = 0; o < P; o++) begin
      m_locked[o] = n_locked[o];
      m_owner[o]  = n_owner[o];
      m_ptr[o]    = n_ptr[o];
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0][1:0] d,
                       input logic [3:0] t, input logic [3:0] rd);
    req = r; dest = d; tail = t; ready = rd;
  endtask

  int seq[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset, then a single-flit packet from input 2 to output 1
    cycle("t1_idle");
    chk("t1_idle_sv", 32'(l_sv), 32'h0);
    chk("t1_idle_gnt", 32'(l_gnt), 32'h0);
    drive(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, 4'b0100, 4'b0010);
    cycle("t1_pkt");
    chk("t1_sel1", 32'(l_sel[1]), 32'd2);
    chk("t1_gnt", 32'(l_gnt), 32'b0100);
    drive(4'b0000, '0, 4'b0000, 4'b0000);
    cycle("t1_after");
    chk("t1_unlock", 32'(l_lock[1]), 32'd0);

    // 2: round robin among inputs 0, 1 and 3 on output 2
    drive(4'b1011, {2'd2, 2'd2, 2'd2, 2'd2}, 4'b1111, 4'b0100);
    for (int k = 0; k < 6; k++) begin
      cycle("t2_rr");
      chk("t2_order", 32'(l_gnt), 32'(1) << seq[k]);
    end

    // 3: wormhole lock. First, move ptr[0] to 1; then input 1 sends 3 flits while input 0 waits.
    drive(4'b0001, '0, 4'b0001, 4'b0001);
    cycle("t3_prep");
    drive(4'b0011, '0, 4'b0001, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) tail = 4'b0011;
      cycle("t3_worm");
      chk("t3_gnt1", 32'(l_gnt), 32'b0010);
      if (k > 0) chk("t3_lock0", 32'(l_lock[0]), 32'd1);
    end
    drive(4'b0001, '0, 4'b0001, 4'b0001);
    cycle("t3_next");
    chk("t3_gnt0", 32'(l_gnt), 32'b0001);

    // 4: stall on output 3 with input 2 as owner while input 0 also requests output 3
    drive(4'b0100, {2'd0, 2'd3, 2'd0, 2'd3}, 4'b0000, 4'b1000);
    cycle("t4_head");
    drive(4'b0101, {2'd0, 2'd3, 2'd0, 2'd3}, 4'b0001, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      cycle("t4_stall");
      chk("t4_sel3", 32'(l_sel[3]), 32'd2);
      chk("t4_nognt", 32'(l_gnt), 32'h0);
      chk("t4_lock3", 32'(l_lock[3]), 32'd1);
    end
    ready = 4'b1000;
    cycle("t4_body");
    chk("t4_body_gnt", 32'(l_gnt), 32'b0100);
    tail = 4'b0101;
    cycle("t4_tail");
    chk("t4_tail_gnt", 32'(l_gnt), 32'b0100);
    drive(4'b0001, {2'd0, 2'd0, 2'd0, 2'd3}, 4'b0001, 4'b1000);
    cycle("t4_next");
    chk("t4_gnt0", 32'(l_gnt), 32'b0001);

    // 5: four disjoint packets at once; input 3's tail wraps ptr[0] to 0
    drive(4'b1111, {2'd0, 2'd3, 2'd2, 2'd1}, 4'b1111, 4'b1111);
    cycle("t5_par");
    chk("t5_all", 32'(l_gnt), 32'hF);
    drive(4'b1001, '0, 4'b1001, 4'b0001);
    cycle("t5_wrap");
    chk("t5_wrap_gnt", 32'(l_gnt), 32'b0001);

    // 6: asynchronous reset while output 1 is locked to input 3
    drive(4'b1000, {2'd1, 2'd0, 2'd0, 2'd0}, 4'b0000, 4'b0010);
    cycle("t6_head");
    chk("t6_locked", 32'(lock[1]), 32'd1);
    drive(4'b0000, '0, 4'b0000, 4'b0000);
    #1 rst = 1'b1;
    #1 chk("t6_async", 32'(lock), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(4'b1001, {2'd1, 2'd0, 2'd0, 2'd1}, 4'b1001, 4'b0010);
    cycle("t6_after");
    chk("t6_gnt0", 32'(l_gnt), 32'b0001);

    // Random traffic, including protocol violations, checked against the model
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom), 8'($urandom), 4'($urandom), 4'($urandom | $urandom));
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
